// File: rtl/alu_pkg.sv
// Shared definitions for the vector ALU and its multi-cycle divide sequencer:
// function codes, lane-width encodings, sequencer states and lane geometry helpers.
package alu_pkg;

    localparam logic [5:0] R_ALU     = 6'b101010;
    localparam logic [5:0] FUNC_VDIV = 6'b001110;
    localparam logic [5:0] FUNC_VMOD = 6'b001111;

    localparam logic [1:0] WIDTH_8  = 2'b00;
    localparam logic [1:0] WIDTH_16 = 2'b01;
    localparam logic [1:0] WIDTH_32 = 2'b10;
    localparam logic [1:0] WIDTH_64 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ITER,
        ST_DONE
    } seq_state_t;

    // Mask selecting one lane's worth of bits, aligned to bit 0.
    function automatic logic [63:0] lane_mask(input logic [1:0] ww);
        case (ww)
            WIDTH_8:  return 64'h0000_0000_0000_00FF;
            WIDTH_16: return 64'h0000_0000_0000_FFFF;
            WIDTH_32: return 64'h0000_0000_FFFF_FFFF;
            default:  return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    // Index of the most significant bit inside a lane (lane width minus one).
    function automatic logic [5:0] lane_top_bit(input logic [1:0] ww);
        case (ww)
            WIDTH_8:  return 6'd7;
            WIDTH_16: return 6'd15;
            WIDTH_32: return 6'd31;
            default:  return 6'd63;
        endcase
    endfunction

    // Index of the last lane (64/w - 1).
    function automatic logic [2:0] last_lane(input logic [1:0] ww);
        case (ww)
            WIDTH_8:  return 3'd7;
            WIDTH_16: return 3'd3;
            WIDTH_32: return 3'd1;
            default:  return 3'd0;
        endcase
    endfunction

    // Right-shift that brings a lane down to bit 0; lane 0 sits at the MSB end.
    function automatic logic [5:0] lane_shift(input logic [1:0] ww, input logic [2:0] lane);
        logic [2:0] rev;
        rev = last_lane(ww) - lane;
        case (ww)
            WIDTH_8:  return {rev, 3'b000};
            WIDTH_16: return {rev[1:0], 4'b0000};
            WIDTH_32: return {rev[0], 5'b00000};
            default:  return 6'd0;
        endcase
    endfunction

    function automatic logic is_div_func(input logic [5:0] func);
        return (func == FUNC_VDIV) || (func == FUNC_VMOD);
    endfunction

endpackage

// File: rtl/alu_div_step.sv
// One restoring-division iteration on a single lane held in the low w bits of
// 64-bit remainder / quotient / divisor words. Purely combinational.
module alu_div_step
    import alu_pkg::*;
(
    input  logic [1:0]  ww,
    input  logic [63:0] rem_in,
    input  logic [63:0] quo_in,
    input  logic [63:0] div_in,
    output logic [63:0] rem_out,
    output logic [63:0] quo_out,
    output logic        qbit
);

    logic [63:0] mask;
    logic        q_msb;
    logic [64:0] shifted;
    logic [64:0] divisor;
    logic [64:0] trial;

    // Shift the next dividend bit into the remainder and trial-subtract the divisor.
    // Because the incoming remainder is always below the divisor (or is a dividend
    // prefix when the divisor is zero), bit 64 of the trial difference is set
    // exactly when the subtraction would go negative.
    always_comb begin
        mask = lane_mask(ww);
        case (ww)
            WIDTH_8:  q_msb = quo_in[7];
            WIDTH_16: q_msb = quo_in[15];
            WIDTH_32: q_msb = quo_in[31];
            default:  q_msb = quo_in[63];
        endcase
        shifted = {rem_in & mask, q_msb};
        divisor = {1'b0, div_in & mask};
        trial   = shifted - divisor;
        qbit    = ~trial[64];
        rem_out = (qbit ? trial[63:0] : shifted[63:0]) & mask;
        quo_out = {quo_in[62:0], qbit} & mask;
    end

endmodule

// File: rtl/alu_vdiv_sequencer.sv
// Multi-cycle VDIV/VMOD sequencer: accepts one lane-partitioned divide op,
// walks the lanes through a shared restoring-divide step, and hands back the
// packed unsigned quotients or remainders over a valid/ready handshake.
module alu_vdiv_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 4
)
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [0:5]        in_R_ins,
    input  logic [0:1]        in_WW,
    input  logic [0:DATA_W-1] in_rA,
    input  logic [0:DATA_W-1] in_rB,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [0:DATA_W-1] out_result,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err,
    output logic              busy
);

    seq_state_t       state;
    logic [63:0]      op_a;
    logic [63:0]      op_b;
    logic [1:0]       ww_q;
    logic             is_mod;
    logic             err_q;
    logic [TAG_W-1:0] tag_q;
    logic [2:0]       lane_idx;
    logic [5:0]       cnt;
    logic [63:0]      quo_q;
    logic [63:0]      rem_q;
    logic [63:0]      res_q;
    logic             result_shown;

    logic [5:0]       lane_sh;
    logic [63:0]      dividend_lane;
    logic [63:0]      div_lane;
    logic [63:0]      lane_value;
    logic [63:0]      merged_result;
    logic [63:0]      step_rem;
    logic [63:0]      step_quo;
    logic             step_qbit;

    assign in_ready = (state == ST_IDLE) & ~flush;
    assign busy     = (state != ST_IDLE);

    alu_div_step u_step (
        .ww      (ww_q),
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .div_in  (div_lane),
        .rem_out (step_rem),
        .quo_out (step_quo),
        .qbit    (step_qbit)
    );

    // Lane geometry for the current lane and the packed result with that lane's answer merged in.
    always_comb begin
        lane_sh       = lane_shift(ww_q, lane_idx);
        dividend_lane = (op_a >> lane_sh) & lane_mask(ww_q);
        div_lane      = (op_b >> lane_sh) & lane_mask(ww_q);
        lane_value    = is_mod ? step_rem : ({quo_q[62:0], step_qbit} & lane_mask(ww_q));
        merged_result = (res_q & ~(lane_mask(ww_q) << lane_sh)) | (lane_value << lane_sh);
    end

    // Sequencer FSM: accept, per-lane load + w iterations, then present the result.
    // DONE spends one cycle raising out_valid and, after the handshake, one cycle
    // with out_valid low so the next accept cannot happen on the handshake edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            op_a         <= '0;
            op_b         <= '0;
            ww_q         <= '0;
            is_mod       <= 1'b0;
            err_q        <= 1'b0;
            tag_q        <= '0;
            lane_idx     <= '0;
            cnt          <= '0;
            quo_q        <= '0;
            rem_q        <= '0;
            res_q        <= '0;
            result_shown <= 1'b0;
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_tag      <= '0;
            out_err      <= 1'b0;
        end else if (flush) begin
            state        <= ST_IDLE;
            out_valid    <= 1'b0;
            result_shown <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_a         <= in_rA;
                        op_b         <= in_rB;
                        ww_q         <= in_WW;
                        is_mod       <= (in_R_ins == FUNC_VMOD);
                        tag_q        <= in_tag;
                        lane_idx     <= '0;
                        cnt          <= '0;
                        res_q        <= '0;
                        result_shown <= 1'b0;
                        if (is_div_func(in_R_ins)) begin
                            err_q <= 1'b0;
                            state <= ST_LOAD;
                        end else begin
                            err_q <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_LOAD: begin
                    quo_q <= dividend_lane;
                    rem_q <= '0;
                    cnt   <= '0;
                    state <= ST_ITER;
                end
                ST_ITER: begin
                    quo_q <= step_quo;
                    rem_q <= step_rem;
                    cnt   <= cnt + 6'd1;
                    if (cnt == lane_top_bit(ww_q)) begin
                        res_q <= merged_result;
                        if (lane_idx == last_lane(ww_q)) begin
                            state <= ST_DONE;
                        end else begin
                            lane_idx <= lane_idx + 3'd1;
                            state    <= ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    if (!result_shown) begin
                        out_valid    <= 1'b1;
                        out_result   <= err_q ? 64'd0 : res_q;
                        out_tag      <= tag_q;
                        out_err      <= err_q;
                        result_shown <= 1'b1;
                    end else if (out_valid) begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                        end
                    end else begin
                        result_shown <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_vdiv_sequencer.sv
// Directed self-checking bench for the VDIV/VMOD sequencer.
module tb_alu_vdiv_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [0:5]  in_R_ins;
    logic [0:1]  in_WW;
    logic [0:63] in_rA;
    logic [0:63] in_rB;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [0:63] out_result;
    logic [3:0]  out_tag;
    logic        out_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    alu_vdiv_sequencer #(.DATA_W(64), .TAG_W(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_R_ins   (in_R_ins),
        .in_WW      (in_WW),
        .in_rA      (in_rA),
        .in_rB      (in_rB),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_err    (out_err),
        .busy       (busy)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", name, observed, expected);
        end
    endtask

    // Present one request for exactly one accept edge, then scramble the inputs.
    task automatic applyStimulus(input logic [5:0] func, input logic [1:0] ww,
                                 input logic [63:0] a, input logic [63:0] b, input logic [3:0] tag);
        in_R_ins = func;
        in_WW    = ww;
        in_rA    = a;
        in_rB    = b;
        in_tag   = tag;
        in_valid = 1'b1;
        checkOutput("in_ready_at_accept", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        in_R_ins = 6'b111111;
        in_WW    = ~ww;
        in_rA    = 64'hDEAD_BEEF_0123_4567;
        in_rB    = 64'h0000_0000_0000_0001;
        in_tag   = ~tag;
    endtask

    // Count edges from the accept edge until out_valid, bounded.
    task automatic waitResult(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
    endtask

    initial begin
        int lat;
        bit seen_valid;

        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_R_ins  = '0;
        in_WW     = '0;
        in_rA     = '0;
        in_rB     = '0;
        in_tag    = '0;
        out_ready = 1'b0;

        #2;
        checkOutput("reset_in_ready",   {63'd0, in_ready},  64'd1);
        checkOutput("reset_out_valid",  {63'd0, out_valid}, 64'd0);
        checkOutput("reset_out_result", out_result,         64'd0);
        checkOutput("reset_out_tag",    {60'd0, out_tag},   64'd0);
        checkOutput("reset_out_err",    {63'd0, out_err},   64'd0);
        checkOutput("reset_busy",       {63'd0, busy},      64'd0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        tick();

        $display("[TB] test 1: 8-bit VDIV 100/7");
        applyStimulus(6'b001110, 2'b00, 64'h6464_6464_6464_6464, 64'h0707_0707_0707_0707, 4'h3);
        checkOutput("t1_busy", {63'd0, busy}, 64'd1);
        waitResult(lat);
        checkOutput("t1_latency", 64'(lat),            64'd73);
        checkOutput("t1_result",  out_result,          64'h0E0E_0E0E_0E0E_0E0E);
        checkOutput("t1_tag",     {60'd0, out_tag},    64'h3);
        checkOutput("t1_err",     {63'd0, out_err},    64'd0);
        consume();

        $display("[TB] test 2: 64-bit VMOD 1000 mod 7");
        applyStimulus(6'b001111, 2'b11, 64'd1000, 64'd7, 4'h5);
        waitResult(lat);
        checkOutput("t2_latency", 64'(lat),         64'd66);
        checkOutput("t2_result",  out_result,       64'd6);
        checkOutput("t2_tag",     {60'd0, out_tag}, 64'h5);
        consume();

        $display("[TB] test 3: 32-bit VDIV/VMOD with a zero divisor lane");
        applyStimulus(6'b001110, 2'b10, 64'h0000_0005_0000_0009, 64'h0000_0000_0000_0003, 4'h7);
        waitResult(lat);
        checkOutput("t3_div_latency", 64'(lat),         64'd67);
        checkOutput("t3_div_result",  out_result,       64'hFFFF_FFFF_0000_0003);
        checkOutput("t3_div_err",     {63'd0, out_err}, 64'd0);
        consume();
        applyStimulus(6'b001111, 2'b10, 64'h0000_0005_0000_0009, 64'h0000_0000_0000_0003, 4'h9);
        waitResult(lat);
        checkOutput("t3_mod_result", out_result,       64'h0000_0005_0000_0000);
        checkOutput("t3_mod_err",    {63'd0, out_err}, 64'd0);

        $display("[TB] test 4: backpressure in DONE");
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("t4_hold_result", out_result,         64'h0000_0005_0000_0000);
            checkOutput("t4_hold_tag",    {60'd0, out_tag},   64'h9);
            checkOutput("t4_hold_ready",  {63'd0, in_ready},  64'd0);
            checkOutput("t4_hold_valid",  {63'd0, out_valid}, 64'd1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("t4_valid_drop",    {63'd0, out_valid}, 64'd0);
        checkOutput("t4_ready_delayed", {63'd0, in_ready},  64'd0);
        tick();
        checkOutput("t4_ready_back",    {63'd0, in_ready},  64'd1);

        $display("[TB] test 5: flush mid-op, then 16-bit VDIV");
        seen_valid = 1'b0;
        applyStimulus(6'b001110, 2'b01, 64'h1234_5678_9ABC_DEF0, 64'h0011_0022_0033_0044, 4'h2);
        for (int i = 1; i < 20; i++) begin
            tick();
            if (out_valid) seen_valid = 1'b1;
        end
        flush = 1'b1;
        #1;
        checkOutput("t5_ready_during_flush", {63'd0, in_ready}, 64'd0);
        tick();
        flush = 1'b0;
        #1;
        checkOutput("t5_ready_after_flush", {63'd0, in_ready}, 64'd1);
        checkOutput("t5_busy_after_flush",  {63'd0, busy},     64'd0);
        for (int i = 0; i < 80; i++) begin
            tick();
            if (out_valid) seen_valid = 1'b1;
        end
        checkOutput("t5_no_valid", {63'd0, seen_valid}, 64'd0);
        applyStimulus(6'b001110, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'h00FF_00FF_00FF_00FF, 4'hC);
        waitResult(lat);
        checkOutput("t5_latency", 64'(lat),         64'd69);
        checkOutput("t5_result",  out_result,       64'h0101_0101_0101_0101);
        checkOutput("t5_tag",     {60'd0, out_tag}, 64'hC);
        consume();

        $display("[TB] test 6: async reset mid-op, then illegal function");
        applyStimulus(6'b001110, 2'b10, 64'h0000_0064_0000_0064, 64'h0000_000A_0000_000A, 4'hE);
        for (int i = 0; i < 10; i++) tick();
        #3 reset_n = 1'b0;
        #1;
        checkOutput("t6_reset_busy",   {63'd0, busy},      64'd0);
        checkOutput("t6_reset_ready",  {63'd0, in_ready},  64'd1);
        checkOutput("t6_reset_valid",  {63'd0, out_valid}, 64'd0);
        checkOutput("t6_reset_result", out_result,         64'd0);
        checkOutput("t6_reset_tag",    {60'd0, out_tag},   64'd0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        tick();
        applyStimulus(6'b000110, 2'b00, 64'h0102_0304_0506_0708, 64'h0101_0101_0101_0101, 4'hA);
        waitResult(lat);
        checkOutput("t6_illegal_latency", 64'(lat),         64'd1);
        checkOutput("t6_illegal_err",     {63'd0, out_err}, 64'd1);
        checkOutput("t6_illegal_result",  out_result,       64'd0);
        checkOutput("t6_illegal_tag",     {60'd0, out_tag}, 64'hA);
        consume();
        checkOutput("t6_final_ready", {63'd0, in_ready}, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
